// File: rtl/clkdiv_pkg.sv
// Shared defaults for the programmable clock divider: channel count, counter
// width, reset half-periods and common half-period constants at 100 MHz.
package clkdiv_pkg;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_CNT_W = 27;

    // Half-period in clk_in cycles, 100 MHz input
    localparam logic [DEF_CNT_W-1:0] HALF_50HZ = 27'd1_000_000;
    localparam logic [DEF_CNT_W-1:0] HALF_30HZ = 27'd1_666_667;
    localparam logic [DEF_CNT_W-1:0] HALF_10HZ = 27'd5_000_000;
    localparam logic [DEF_CNT_W-1:0] HALF_1HZ  = 27'd50_000_000;

    // Packed ch3..ch0
    localparam logic [DEF_N_CH*DEF_CNT_W-1:0] DEF_HALF_INIT =
        {HALF_1HZ, 27'd5, 27'd2, 27'd1};

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: up-counter against the active half-period, with a
// shadow register so ratio changes only take effect on a toggle.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int               CNT_W = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DEF   = '0
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] h_act;
    logic [CNT_W-1:0] h_shd;
    logic             last;

    // h_act is never zero: reset values and accepted writes are nonzero
    assign last = (cnt == h_act - 1'b1);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            h_act   <= DEF;
            h_shd   <= DEF;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (wr) h_shd <= wr_half;
            if (sync_clr || !en) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
                h_act   <= h_shd;
            end else if (last) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= ~clk_out;
                h_act   <= h_shd;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: config write decode, sticky
// config error flag, and one clkdiv_channel per output.
module prog_clk_divider
    import clkdiv_pkg::*;
#(
    parameter int                      N_CH     = DEF_N_CH,
    parameter int                      CNT_W    = DEF_CNT_W,
    parameter logic [N_CH*CNT_W-1:0]   DEF_HALF = DEF_HALF_INIT
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [N_CH-1:0]  en,
    input  logic             sync_clr,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_ch,
    input  logic [CNT_W-1:0] cfg_half,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic             cfg_err
);

    logic cfg_valid;

    assign cfg_valid = ({1'b0, cfg_ch} < 5'(N_CH)) && (cfg_half != '0);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)                      cfg_err <= 1'b0;
        else if (cfg_we && !cfg_valid)  cfg_err <= 1'b1;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clkdiv_channel #(
            .CNT_W (CNT_W),
            .DEF   (DEF_HALF[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk_in   (clk_in),
            .reset    (reset),
            .en       (en[i]),
            .sync_clr (sync_clr),
            .wr       (cfg_we && cfg_valid && (cfg_ch == 4'(i))),
            .wr_half  (cfg_half),
            .clk_out  (clk_out[i]),
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: event-scheduled reference model compared every
// cycle, plus directed checks on periods, config handling, sync and reset.
module tb_prog_clk_divider;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b0;
    logic [3:0]  en     = 4'b0111;
    logic        sync_clr = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_ch = 4'd0;
    logic [26:0] cfg_half = 27'd0;
    logic [3:0]  clk_out;
    logic [3:0]  tick;
    logic        cfg_err;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    prog_clk_divider dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .en       (en),
        .sync_clr (sync_clr),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
        .clk_out  (clk_out),
        .tick     (tick),
        .cfg_err  (cfg_err)
    );

    initial forever #5 clk_in = ~clk_in;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each channel schedules its next toggle as an absolute edge number
    int m_level [4];
    int m_tick  [4];
    int m_act   [4];
    int m_shd   [4];
    int m_next  [4];
    int m_cyc;
    bit m_err;
    int def_half [4] = '{1, 2, 5, 50_000_000};

    always @(posedge clk_in or posedge reset) begin
        if (reset) begin
            m_cyc = 0;
            m_err = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_level[i] = 0;
                m_tick[i]  = 0;
                m_act[i]   = def_half[i];
                m_shd[i]   = def_half[i];
                m_next[i]  = def_half[i];
            end
        end else begin
            bit valid;
            m_cyc++;
            valid = (int'(cfg_ch) < 4) && (cfg_half != 0);
            if (cfg_we && !valid) m_err = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (sync_clr || !en[i]) begin
                    m_level[i] = 0;
                    m_tick[i]  = 0;
                    m_act[i]   = m_shd[i];
                    m_next[i]  = m_cyc + m_act[i];
                end else if (m_cyc == m_next[i]) begin
                    m_tick[i]  = (m_level[i] == 0) ? 1 : 0;
                    m_level[i] = 1 - m_level[i];
                    m_act[i]   = m_shd[i];
                    m_next[i]  = m_cyc + m_act[i];
                end else begin
                    m_tick[i] = 0;
                end
                if (cfg_we && valid && int'(cfg_ch) == i) m_shd[i] = int'(cfg_half);
            end
        end
    end

    always @(negedge clk_in) begin
        if (chk_en && !reset) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("model_clk_out%0d", i), int'(clk_out[i]), m_level[i]);
                check($sformatf("model_tick%0d", i), int'(tick[i]), m_tick[i]);
            end
            check("model_cfg_err", int'(cfg_err), int'(m_err));
        end
    end

    task automatic wait_tick(input int ch, input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk_in);
            if (tick[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic wait_both(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk_in);
            if (tick[0] && tick[1]) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic cfg_write(input logic [3:0] ch, input logic [26:0] half);
        @(negedge clk_in);
        cfg_we = 1'b1;
        cfg_ch = ch;
        cfg_half = half;
        @(negedge clk_in);
        cfg_we = 1'b0;
    endtask

    initial begin
        int d;
        int p;
        #2 reset = 1'b1;
        #10 reset = 1'b0;
        chk_en = 1'b1;
        check("reset_clk_out", int'(clk_out), 0);
        check("reset_cfg_err", int'(cfg_err), 0);

        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        check("tick2_before_first", int'(tick[2]), 0);
        @(negedge clk_in);
        check("tick2_first_after_5", int'(tick[2]), 1);

        wait_tick(0, 50, d); wait_tick(0, 50, p); check("period_ch0", p, 2);
        wait_tick(1, 50, d); wait_tick(1, 50, p); check("period_ch1", p, 4);
        wait_tick(2, 50, d); wait_tick(2, 50, p); check("period_ch2", p, 10);

        repeat (3) @(negedge clk_in);
        cfg_write(4'd1, 27'd7);
        wait_tick(1, 50, d); wait_tick(1, 50, p); check("period_ch1_after_cfg7", p, 14);
        wait_tick(1, 50, p); check("period_ch1_cfg7_again", p, 14);

        cfg_write(4'd5, 27'd3);
        check("cfg_err_bad_ch", int'(cfg_err), 1);
        cfg_write(4'd0, 27'd0);
        wait_tick(0, 50, d); wait_tick(0, 50, p); check("period_ch0_after_zero", p, 2);

        cfg_write(4'd0, 27'd3);
        repeat (30) @(negedge clk_in);
        sync_clr = 1'b1;
        @(negedge clk_in);
        sync_clr = 1'b0;
        check("sync_clk_out_low", int'(clk_out[2:0]), 0);
        wait_both(100, p); check("sync_first_coincident", p, 21);
        wait_both(100, p); check("sync_lcm_period", p, 42);
        check("cfg_err_sticky", int'(cfg_err), 1);

        @(negedge clk_in);
        en = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            check("en2_low_parks", int'(clk_out[2]), 0);
        end
        en = 4'b0111;
        wait_tick(2, 50, p); check("en2_restart_full_half", p, 5);

        repeat (3) @(negedge clk_in);
        #2 reset = 1'b1;
        #1;
        check("async_reset_clk_out", int'(clk_out), 0);
        check("async_reset_tick", int'(tick), 0);
        check("async_reset_cfg_err", int'(cfg_err), 0);
        @(negedge clk_in);
        reset = 1'b0;
        wait_tick(1, 50, d); wait_tick(1, 50, p); check("period_ch1_default_after_reset", p, 4);
        repeat (20) @(negedge clk_in);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
